note_sequencer: RTL and testbench

Song player that sits directly upstream of the sine note decoder and drives its 10-bit note input. It walks a song table held in an external synchronous ROM. Each table entry pairs a note code with a duration in beats. The block holds each note for an exact number of clock cycles, inserts a short silent gap between notes, and then stops or loops at an end-of-song terminator.

---
 rtl/note_sequencer_pkg.sv | 27 ++
 rtl/note_sequencer_if.sv | 29 ++
 rtl/note_sequencer_beat_tick_gen.sv | 38 +++
 rtl/note_sequencer.sv | 161 ++++++++++++++++
 tb/tb_note_sequencer.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/note_sequencer_pkg.sv
// Shared definitions for the note sequencer: song-entry layout, rest code, FSM states.
package note_sequencer_pkg;

  localparam int unsigned NOTE_LSB = 0;
  localparam int unsigned NOTE_W   = 10;
  localparam int unsigned DUR_LSB  = 10;
  localparam int unsigned DUR_W    = 6;

  localparam logic [NOTE_W-1:0] REST_CODE = 10'h3FF;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    PLAY,
    GAP
  } seq_state_e;

  function automatic logic [NOTE_W-1:0] entry_note(input logic [15:0] word);
    return word[NOTE_LSB +: NOTE_W];
  endfunction

  function automatic logic [DUR_W-1:0] entry_dur(input logic [15:0] word);
    return word[DUR_LSB +: DUR_W];
  endfunction

endpackage

// File: rtl/note_sequencer_if.sv
// Control, song-ROM and decoder-facing signals of the note sequencer.
interface note_sequencer_if #(
  parameter int unsigned ADDR_W = 8
) ();

  logic                                start;
  logic                                stop;
  logic                                loop_en;
  logic [ADDR_W-1:0]                   rom_addr;
  logic [15:0]                         rom_data;
  logic [note_sequencer_pkg::NOTE_W-1:0] note;
  logic                                gate;
  logic                                note_strobe;
  logic                                busy;
  logic                                done;

  // Sequencer side
  modport master (
    input  start, stop, loop_en, rom_data,
    output rom_addr, note, gate, note_strobe, busy, done
  );

  // Controller / ROM / decoder side
  modport slave (
    output start, stop, loop_en, rom_data,
    input  rom_addr, note, gate, note_strobe, busy, done
  );

endinterface

// File: rtl/note_sequencer_beat_tick_gen.sv
// Clear-able modulo-TICK_DIV counter producing a one-cycle beat tick.
module beat_tick_gen #(
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned    CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise wrap at TICK_DIV-1 while enabled
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/note_sequencer.sv
// Song player: walks a song ROM, holds each note for duration*TICK_DIV cycles,
// inserts a silent gap, and stops or loops at a zero-duration terminator.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned TICK_DIV   = 12500000,
  parameter int unsigned GAP_CYCLES = 250000
) (
  input  logic              clk,
  input  logic              reset,
  note_sequencer_if.master  bus
);

  localparam int unsigned      GAP_W    = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              gate_q, gate_d;
  logic              note_strobe_q, note_strobe_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              tick;
  logic              div_clr;
  logic              div_en;

  // The divider only runs in PLAY; leaving PLAY (or stop) restarts it from zero
  assign div_en  = (state_q == PLAY);
  assign div_clr = (state_q != PLAY) || bus.stop;

  beat_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_beat_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .en    (div_en),
    .tick  (tick)
  );

  // Next-state and output logic; stop overrides whatever the FSM decided
  always_comb begin
    state_d       = state_q;
    rom_addr_d    = rom_addr_q;
    note_d        = note_q;
    gate_d        = gate_q;
    note_strobe_d = 1'b0;
    done_d        = 1'b0;
    dur_d         = dur_q;
    gap_d         = gap_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          rom_addr_d = '0;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        if (entry_dur(bus.rom_data) == '0) begin
          if (bus.loop_en) begin
            rom_addr_d = '0;
            state_d    = FETCH;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          note_d        = entry_note(bus.rom_data);
          dur_d         = entry_dur(bus.rom_data);
          note_strobe_d = 1'b1;
          gate_d        = (entry_note(bus.rom_data) != REST_CODE);
          state_d       = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dur_q == DUR_W'(1)) begin
            gate_d = 1'b0;
            dur_d  = '0;
            if (GAP_CYCLES == 0) begin
              rom_addr_d = rom_addr_q + ADDR_W'(1);
              state_d    = FETCH;
            end else begin
              gap_d   = GAP_LOAD;
              state_d = GAP;
            end
          end else begin
            dur_d = dur_q - DUR_W'(1);
          end
        end
      end
      GAP: begin
        if (gap_q == GAP_W'(1)) begin
          gap_d      = '0;
          rom_addr_d = rom_addr_q + ADDR_W'(1);
          state_d    = FETCH;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort: back to IDLE silently, note and address are held
    if (bus.stop) begin
      state_d       = IDLE;
      rom_addr_d    = rom_addr_q;
      note_d        = note_q;
      gate_d        = 1'b0;
      note_strobe_d = 1'b0;
      done_d        = 1'b0;
      dur_d         = '0;
      gap_d         = '0;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      rom_addr_q    <= '0;
      note_q        <= '0;
      gate_q        <= 1'b0;
      note_strobe_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      dur_q         <= '0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      rom_addr_q    <= rom_addr_d;
      note_q        <= note_d;
      gate_q        <= gate_d;
      note_strobe_q <= note_strobe_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      dur_q         <= dur_d;
      gap_q         <= gap_d;
    end
  end

  assign bus.rom_addr    = rom_addr_q;
  assign bus.note        = note_q;
  assign bus.gate        = gate_q;
  assign bus.note_strobe = note_strobe_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: directed table, hand sequences and randomized songs
// checked against a timeline model built from the song table.
module tb_note_sequencer;

  localparam int unsigned A_TICK = 4;
  localparam int unsigned A_GAP  = 2;
  localparam int unsigned B_TICK = 1;
  localparam int unsigned B_GAP  = 0;

  typedef struct packed {
    logic [7:0] addr;
    logic [9:0] note;
    logic       gate;
    logic       strobe;
    logic       busy;
    logic       done;
  } obs_t;

  typedef struct {
    int unsigned first;
    int unsigned last;
    logic        start;
    obs_t        exp;
  } seg_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [4];
  logic [9:0]  held_a;
  logic [9:0]  held_b;
  obs_t        exp_q [$];
  seg_t        segs [$];

  int n_checks = 0;
  int n_fail   = 0;

  note_sequencer_if #(.ADDR_W(8)) bus_a ();
  note_sequencer_if #(.ADDR_W(2)) bus_b ();

  note_sequencer #(.ADDR_W(8), .TICK_DIV(A_TICK), .GAP_CYCLES(A_GAP)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  note_sequencer #(.ADDR_W(2), .TICK_DIV(B_TICK), .GAP_CYCLES(B_GAP)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  always #5 clk = ~clk;

  // Synchronous song ROMs: data valid one cycle after the address
  always @(posedge clk) bus_a.rom_data <= rom_a[bus_a.rom_addr];
  always @(posedge clk) bus_b.rom_data <= rom_b[bus_b.rom_addr];

  function automatic obs_t mk(input logic [7:0] addr, input logic [9:0] note,
                              input logic gate, input logic strobe,
                              input logic busy, input logic done);
    obs_t o;
    o.addr = addr; o.note = note; o.gate = gate;
    o.strobe = strobe; o.busy = busy; o.done = done;
    return o;
  endfunction

  function automatic obs_t sample(input bit use_b);
    if (use_b)
      return mk(8'(bus_b.rom_addr), bus_b.note, bus_b.gate, bus_b.note_strobe, bus_b.busy, bus_b.done);
    return mk(bus_a.rom_addr, bus_a.note, bus_a.gate, bus_a.note_strobe, bus_a.busy, bus_a.done);
  endfunction

  // Expected per-cycle outputs after a start, derived from the song rules:
  // 2 fetch cycles per entry, dur*TICK cycles of note, GAP cycles of silence.
  function automatic void build_timeline(input bit use_b, input logic loop,
                                         input logic [9:0] held_in, input int unsigned limit);
    int unsigned addr  = 0;
    int unsigned depth = use_b ? 4 : 256;
    int unsigned tick  = use_b ? B_TICK : A_TICK;
    int unsigned gap   = use_b ? B_GAP : A_GAP;
    logic [9:0]  held  = held_in;
    logic [15:0] w;
    int unsigned dur;
    exp_q.delete();
    while (exp_q.size() < limit) begin
      w = use_b ? rom_b[addr] : rom_a[addr];
      exp_q.push_back(mk(8'(addr), held, 1'b0, 1'b0, 1'b1, 1'b0));
      exp_q.push_back(mk(8'(addr), held, 1'b0, 1'b0, 1'b1, 1'b0));
      dur = int'(w[15:10]);
      if (dur == 0) begin
        if (loop) begin
          addr = 0;
          continue;
        end
        exp_q.push_back(mk(8'(addr), held, 1'b0, 1'b0, 1'b0, 1'b1));
        while (exp_q.size() < limit)
          exp_q.push_back(mk(8'(addr), held, 1'b0, 1'b0, 1'b0, 1'b0));
        break;
      end
      held = w[9:0];
      for (int unsigned i = 0; i < dur * tick; i++)
        exp_q.push_back(mk(8'(addr), held, held != 10'h3FF, i == 0, 1'b1, 1'b0));
      for (int unsigned g = 0; g < gap; g++)
        exp_q.push_back(mk(8'(addr), held, 1'b0, 1'b0, 1'b1, 1'b0));
      addr = (addr + 1) % depth;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit use_b, input logic s, input logic p);
    if (use_b) begin bus_b.start = s; bus_b.stop = p; end
    else       begin bus_a.start = s; bus_a.stop = p; end
  endtask

  task automatic check(input string name, input int cyc, input obs_t got,
                       input obs_t exp, input obs_t mask);
    n_checks++;
    if ((got & mask) !== (exp & mask)) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got addr=%0h note=%0h gate=%0b strobe=%0b busy=%0b done=%0b; want addr=%0h note=%0h gate=%0b strobe=%0b busy=%0b done=%0b",
               name, cyc, got.addr, got.note, got.gate, got.strobe, got.busy, got.done,
               exp.addr, exp.note, exp.gate, exp.strobe, exp.busy, exp.done);
    end
  endtask

  // Start playback, compare every cycle to the model, stop in cycle stop_at,
  // then confirm the silent IDLE cycle that follows.
  task automatic play(input bit use_b, input logic loop, input int unsigned stop_at,
                      input bit rand_starts, input string name);
    obs_t        e;
    obs_t        mask_full;
    obs_t        mask_noaddr;
    logic [9:0]  stop_note;
    mask_full   = '1;
    mask_noaddr = mk(8'h00, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1);
    stop_note   = '0;
    build_timeline(use_b, loop, use_b ? held_b : held_a, stop_at);
    if (use_b) bus_b.loop_en = loop; else bus_a.loop_en = loop;
    drive(use_b, 1'b1, 1'b0);
    step();
    drive(use_b, 1'b0, 1'b0);
    for (int unsigned k = 1; k <= stop_at + 1; k++) begin
      if (k <= stop_at) begin
        e = exp_q[k-1];
        check(name, int'(k), sample(use_b), e, mask_full);
      end else begin
        e = mk(8'h00, stop_note, 1'b0, 1'b0, 1'b0, 1'b0);
        check(name, int'(k), sample(use_b), e, mask_noaddr);
      end
      if (k == stop_at) begin
        stop_note = e.note;
        drive(use_b, 1'b0, 1'b1);
      end else if (rand_starts && e.busy && $urandom_range(7) == 0) begin
        drive(use_b, 1'b1, 1'b0);
      end
      step();
      drive(use_b, 1'b0, 1'b0);
    end
    if (use_b) held_b = stop_note; else held_a = stop_note;
  endtask

  initial begin
    obs_t mask_full;
    obs_t mask_noaddr;
    obs_t got;
    int   fetch_addr [$];
    mask_full   = '1;
    mask_noaddr = mk(8'h00, 10'h3FF, 1'b1, 1'b1, 1'b1, 1'b1);

    for (int i = 0; i < 256; i++) rom_a[i] = '0;
    rom_a[0] = {6'd2, 10'd5};
    rom_a[1] = {6'd1, 10'h3FF};
    rom_a[2] = {6'd0, 10'd0};
    rom_b[0] = {6'd1, 10'd1};
    rom_b[1] = {6'd1, 10'd2};
    rom_b[2] = {6'd1, 10'd3};
    rom_b[3] = {6'd1, 10'd4};
    bus_a.start = 1'b0; bus_a.stop = 1'b0; bus_a.loop_en = 1'b0;
    bus_b.start = 1'b0; bus_b.stop = 1'b0; bus_b.loop_en = 1'b0;

    // 1: reset held with start asserted
    reset = 1'b1;
    bus_a.start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset", i, sample(1'b0), '0, mask_full);
    end
    reset = 1'b0;
    bus_a.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("post_reset", i, sample(1'b0), '0, mask_full);
      check("post_reset_b", i, sample(1'b1), '0, mask_full);
    end

    // 2+3: first note, rest, gap and end of song as explicit vectors
    segs.push_back('{0,  0,  1'b1, mk(8'd0, 10'h000, 0, 0, 0, 0)});
    segs.push_back('{1,  2,  1'b0, mk(8'd0, 10'h000, 0, 0, 1, 0)});
    segs.push_back('{3,  3,  1'b0, mk(8'd0, 10'h005, 1, 1, 1, 0)});
    segs.push_back('{4,  10, 1'b0, mk(8'd0, 10'h005, 1, 0, 1, 0)});
    segs.push_back('{11, 12, 1'b0, mk(8'd0, 10'h005, 0, 0, 1, 0)});
    segs.push_back('{13, 14, 1'b0, mk(8'd1, 10'h005, 0, 0, 1, 0)});
    segs.push_back('{15, 15, 1'b0, mk(8'd1, 10'h3FF, 0, 1, 1, 0)});
    segs.push_back('{16, 20, 1'b0, mk(8'd1, 10'h3FF, 0, 0, 1, 0)});
    segs.push_back('{21, 22, 1'b0, mk(8'd2, 10'h3FF, 0, 0, 1, 0)});
    segs.push_back('{23, 23, 1'b0, mk(8'd2, 10'h3FF, 0, 0, 0, 1)});
    segs.push_back('{24, 25, 1'b0, mk(8'd2, 10'h3FF, 0, 0, 0, 0)});
    bus_a.loop_en = 1'b0;
    foreach (segs[s]) begin
      for (int unsigned k = segs[s].first; k <= segs[s].last; k++) begin
        check("song_table", int'(k), sample(1'b0), segs[s].exp, mask_full);
        bus_a.start = segs[s].start;
        step();
        bus_a.start = 1'b0;
      end
    end
    held_a = 10'h3FF;

    // 4: looping song for three passes, no done pulse expected
    play(1'b0, 1'b1, 3 * 22 + 4, 1'b0, "loop");

    // 5: stop during the first note, then start+stop together from IDLE
    bus_a.loop_en = 1'b0;
    bus_a.start = 1'b1;
    step();
    bus_a.start = 1'b0;
    for (int i = 1; i < 6; i++) step();
    check("pre_stop", 6, sample(1'b0), mk(8'd0, 10'h005, 1, 0, 1, 0), mask_full);
    bus_a.stop = 1'b1;
    step();
    bus_a.stop = 1'b0;
    check("stop_mid_note", 7, sample(1'b0), mk(8'd0, 10'h005, 0, 0, 0, 0), mask_noaddr);
    held_a = 10'h005;
    bus_a.start = 1'b1;
    bus_a.stop  = 1'b1;
    step();
    bus_a.start = 1'b0;
    bus_a.stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("start_stop_idle", i, sample(1'b0), mk(8'd0, 10'h005, 0, 0, 0, 0), mask_noaddr);
      step();
    end
    play(1'b0, 1'b0, 30, 1'b0, "replay");

    // 6: address wrap on a 4-entry table without terminator
    play(1'b1, 1'b0, 20, 1'b1, "wrap");
    bus_b.loop_en = 1'b0;
    bus_b.start = 1'b1;
    step();
    bus_b.start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      got = sample(1'b1);
      if (i % 3 == 0) fetch_addr.push_back(int'(got.addr));
      if (got.busy && $urandom_range(3) == 0) bus_b.start = 1'b1;
      step();
      bus_b.start = 1'b0;
    end
    bus_b.stop = 1'b1;
    step();
    bus_b.stop = 1'b0;
    foreach (fetch_addr[i]) begin
      n_checks++;
      if (fetch_addr[i] != (i % 4)) begin
        n_fail++;
        $display("FAIL wrap_seq idx %0d: got rom_addr=%0d want %0d", i, fetch_addr[i], i % 4);
      end
    end
    held_b = 10'd2;

    // Randomized songs against the timeline model
    for (int it = 0; it < 12; it++) begin
      for (int i = 0; i < 6; i++) begin
        rom_a[i][9:0]   = ($urandom_range(3) == 0) ? 10'h3FF : 10'($urandom_range(1022));
        rom_a[i][15:10] = ($urandom_range(4) == 0) ? 6'd0 : 6'($urandom_range(3, 1));
      end
      rom_a[6] = '0;
      play(1'b0, 1'($urandom_range(1)), $urandom_range(90, 1), 1'b1, "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
